// File: rtl/ram_arbiter_if.sv
// Bus bundle between the three RAM requesters (IF, DM, HS), the arbiter and the RAM array.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;
    logic              if_rvalid;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_rvalid;

    logic              hs_req;
    logic              hs_we;
    logic [ADDR_W-1:0] hs_addr;
    logic [DATA_W-1:0] hs_wdata;
    logic              hs_lock;
    logic              hs_gnt;
    logic [DATA_W-1:0] hs_rdata;
    logic              hs_rvalid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  hs_req, hs_we, hs_addr, hs_wdata, hs_lock,
        input  mem_rdata,
        output if_gnt, if_rdata, if_rvalid,
        output dm_gnt, dm_rdata, dm_rvalid,
        output hs_gnt, hs_rdata, hs_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output hs_req, hs_we, hs_addr, hs_wdata, hs_lock,
        output mem_rdata,
        input  if_gnt, if_rdata, if_rvalid,
        input  dm_gnt, dm_rdata, dm_rvalid,
        input  hs_gnt, hs_rdata, hs_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between fetch, data and host,
// with a registered command stage and tagged read-data return (accept -> rvalid in 2 edges).
//
// arbitration state | meaning
// last_gnt          | requester of the most recent accept; search starts at the next one
// lock_q            | last accept was HS with hs_lock set; HS keeps winning while lock held
module ram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_arbiter_if.slave bus
);
    localparam logic [1:0] ID_IF = 2'd0;
    localparam logic [1:0] ID_DM = 2'd1;
    localparam logic [1:0] ID_HS = 2'd2;

    logic [1:0]        last_gnt;
    logic              lock_q;
    logic [3:0]        req4;
    logic [2:0]        gnt;
    logic [1:0]        win;
    logic [1:0]        p0, p1, p2;
    logic              any_req;
    logic              lock_win;
    logic              accept;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [1:0]        cmd_tag;
    logic              ret_pend;
    logic [1:0]        ret_tag;
    logic [2:0]        rvalid_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q, hs_rdata_q;

    assign req4     = {1'b0, bus.hs_req, bus.dm_req, bus.if_req};
    assign lock_win = lock_q & bus.hs_req & bus.hs_lock;

    always_comb begin
        p0 = ID_IF;
        p1 = ID_DM;
        p2 = ID_HS;
        case (last_gnt)
            ID_IF:   begin p0 = ID_DM; p1 = ID_HS; p2 = ID_IF; end
            ID_DM:   begin p0 = ID_HS; p1 = ID_IF; p2 = ID_DM; end
            default: ;
        endcase
        win     = ID_IF;
        any_req = 1'b0;
        if (lock_win)      begin win = ID_HS; any_req = 1'b1; end
        else if (req4[p0]) begin win = p0;    any_req = 1'b1; end
        else if (req4[p1]) begin win = p1;    any_req = 1'b1; end
        else if (req4[p2]) begin win = p2;    any_req = 1'b1; end
        // grants are forced low while reset is asserted
        gnt = 3'b000;
        if (any_req && rst_n) begin
            case (win)
                ID_IF:   gnt[0] = 1'b1;
                ID_DM:   gnt[1] = 1'b1;
                default: gnt[2] = 1'b1;
            endcase
        end
    end

    assign accept = |gnt;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = bus.if_addr;
        sel_wdata = '0;
        case (win)
            ID_DM:   begin sel_we = bus.dm_we; sel_addr = bus.dm_addr; sel_wdata = bus.dm_wdata; end
            ID_HS:   begin sel_we = bus.hs_we; sel_addr = bus.hs_addr; sel_wdata = bus.hs_wdata; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt    <= ID_HS;
            lock_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cmd_tag     <= ID_IF;
            ret_pend    <= 1'b0;
            ret_tag     <= ID_IF;
            rvalid_q    <= 3'b000;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            hs_rdata_q  <= '0;
        end else begin
            lock_q   <= accept && (win == ID_HS) && bus.hs_lock;
            mem_en_q <= accept;
            if (accept) begin
                last_gnt    <= win;
                mem_we_q    <= sel_we;
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
                cmd_tag     <= win;
            end
            // RAM samples the command one edge later; its data is captured the edge after that
            ret_pend <= mem_en_q & ~mem_we_q;
            ret_tag  <= cmd_tag;
            rvalid_q <= 3'b000;
            if (ret_pend) begin
                case (ret_tag)
                    ID_IF:   begin rvalid_q[0] <= 1'b1; if_rdata_q <= bus.mem_rdata; end
                    ID_DM:   begin rvalid_q[1] <= 1'b1; dm_rdata_q <= bus.mem_rdata; end
                    default: begin rvalid_q[2] <= 1'b1; hs_rdata_q <= bus.mem_rdata; end
                endcase
            end
        end
    end

    assign bus.if_gnt    = gnt[0];
    assign bus.dm_gnt    = gnt[1];
    assign bus.hs_gnt    = gnt[2];
    assign bus.if_rvalid = rvalid_q[0];
    assign bus.dm_rvalid = rvalid_q[1];
    assign bus.hs_rvalid = rvalid_q[2];
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.hs_rdata  = hs_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = mem_en_q | ret_pend;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a cycle table for reset, single read, round-robin and idle,
// then hand sequences for write-then-read, host lock and reset during an in-flight read.
module tb_ram_arbiter;
    localparam logic [11:0] A  = 12'h010;
    localparam logic [11:0] B  = 12'h020;
    localparam logic [31:0] D1 = 32'hDEADBEEF;
    localparam logic [31:0] D2 = 32'h12345678;
    localparam int NV = 17;

    typedef struct {
        logic        rst;
        logic [2:0]  req;      // {hs, dm, if}
        logic        dm_we;
        logic        hs_we;
        logic [11:0] dm_a;
        logic [11:0] hs_a;
        logic [31:0] dm_d;
        logic [31:0] hs_d;
        logic [2:0]  gnt;
        logic [13:0] mem;      // {mem_en, mem_we, mem_addr}
        logic [2:0]  rv;
        logic [31:0] if_rd;
        logic [31:0] dm_rd;
        logic [31:0] hs_rd;
        logic        busy;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [NV];

    ram_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    ram_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [4096];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    logic [2:0]  gnt_v, rv_v;
    logic [13:0] mem_v;
    assign gnt_v = {bus.hs_gnt, bus.dm_gnt, bus.if_gnt};
    assign rv_v  = {bus.hs_rvalid, bus.dm_rvalid, bus.if_rvalid};
    assign mem_v = {bus.mem_en, bus.mem_we, bus.mem_addr};

    function automatic vec_t mk(input logic rst, input logic [2:0] req, input logic dmw, input logic hsw,
                                input logic [11:0] dma, input logic [11:0] hsa, input logic [31:0] dmd,
                                input logic [31:0] hsd, input logic [2:0] gnt, input logic [1:0] enwe,
                                input logic [11:0] ma, input logic [2:0] rv, input logic [31:0] ird,
                                input logic [31:0] drd, input logic [31:0] hrd, input logic busy);
        vec_t v;
        v.rst = rst;   v.req = req;   v.dm_we = dmw;  v.hs_we = hsw;
        v.dm_a = dma;  v.hs_a = hsa;  v.dm_d = dmd;   v.hs_d = hsd;
        v.gnt = gnt;   v.mem = {enwe, ma};            v.rv = rv;
        v.if_rd = ird; v.dm_rd = drd; v.hs_rd = hrd;  v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic dmw, input logic hsw, input logic lk,
                         input logic [11:0] ia, input logic [11:0] da, input logic [11:0] ha,
                         input logic [31:0] dd, input logic [31:0] hd);
        bus.if_req   = req[0];
        bus.if_addr  = ia;
        bus.dm_req   = req[1];
        bus.dm_we    = dmw;
        bus.dm_addr  = da;
        bus.dm_wdata = dd;
        bus.hs_req   = req[2];
        bus.hs_we    = hsw;
        bus.hs_addr  = ha;
        bus.hs_wdata = hd;
        bus.hs_lock  = lk;
    endtask

    initial begin
        //            rst req     dmw   hsw   dma hsa dmd hsd  gnt     enwe   ma  rv      if  dm  hs  busy
        tbl[0]  = mk(0, 3'b010, 1'b1, 1'b0, A, A, D1, 0,  3'b010, 2'b00, 0, 3'b000, 0,  0,  0,  0);
        tbl[1]  = mk(0, 3'b100, 1'b0, 1'b1, A, B, 0,  D2, 3'b100, 2'b11, A, 3'b000, 0,  0,  0,  1);
        tbl[2]  = mk(0, 3'b001, 1'b0, 1'b0, A, A, 0,  0,  3'b001, 2'b11, B, 3'b000, 0,  0,  0,  1);
        tbl[3]  = mk(0, 3'b000, 1'b0, 1'b0, A, A, 0,  0,  3'b000, 2'b10, A, 3'b000, 0,  0,  0,  1);
        tbl[4]  = mk(0, 3'b000, 1'b0, 1'b0, A, A, 0,  0,  3'b000, 2'b00, A, 3'b000, 0,  0,  0,  1);
        tbl[5]  = mk(0, 3'b000, 1'b0, 1'b0, A, A, 0,  0,  3'b000, 2'b00, A, 3'b001, D1, 0,  0,  0);
        tbl[6]  = mk(0, 3'b000, 1'b0, 1'b0, A, A, 0,  0,  3'b000, 2'b00, A, 3'b000, D1, 0,  0,  0);
        tbl[7]  = mk(1, 3'b111, 1'b0, 1'b0, B, A, 0,  0,  3'b000, 2'b00, 0, 3'b000, 0,  0,  0,  0);
        tbl[8]  = mk(0, 3'b111, 1'b0, 1'b0, B, A, 0,  0,  3'b001, 2'b00, 0, 3'b000, 0,  0,  0,  0);
        tbl[9]  = mk(0, 3'b111, 1'b0, 1'b0, B, A, 0,  0,  3'b010, 2'b10, A, 3'b000, 0,  0,  0,  1);
        tbl[10] = mk(0, 3'b111, 1'b0, 1'b0, B, A, 0,  0,  3'b100, 2'b10, B, 3'b000, 0,  0,  0,  1);
        tbl[11] = mk(0, 3'b111, 1'b0, 1'b0, B, A, 0,  0,  3'b001, 2'b10, A, 3'b001, D1, 0,  0,  1);
        tbl[12] = mk(0, 3'b111, 1'b0, 1'b0, B, A, 0,  0,  3'b010, 2'b10, A, 3'b010, D1, D2, 0,  1);
        tbl[13] = mk(0, 3'b111, 1'b0, 1'b0, B, A, 0,  0,  3'b100, 2'b10, B, 3'b100, D1, D2, D1, 1);
        tbl[14] = mk(0, 3'b000, 1'b0, 1'b0, B, A, 0,  0,  3'b000, 2'b10, A, 3'b001, D1, D2, D1, 1);
        tbl[15] = mk(0, 3'b000, 1'b0, 1'b0, B, A, 0,  0,  3'b000, 2'b00, A, 3'b010, D1, D2, D1, 1);
        tbl[16] = mk(0, 3'b000, 1'b0, 1'b0, B, A, 0,  0,  3'b000, 2'b00, A, 3'b100, D1, D2, D1, 0);

        rst_n = 1'b0;
        drive(3'b111, 1'b0, 1'b0, 1'b0, A, A, A, 0, 0);
        @(negedge clk);
        #1;
        chk("rst_gnt",  0, 64'(gnt_v), 64'(3'b000));
        chk("rst_mem",  0, 64'(mem_v), 64'(14'h0));
        chk("rst_wd",   0, 64'(bus.mem_wdata), 64'(32'h0));
        chk("rst_rv",   0, 64'(rv_v), 64'(3'b000));
        chk("rst_busy", 0, 64'(bus.busy), 64'(1'b0));

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n = ~tbl[i].rst;
            drive(tbl[i].req, tbl[i].dm_we, tbl[i].hs_we, 1'b0, A, tbl[i].dm_a, tbl[i].hs_a,
                  tbl[i].dm_d, tbl[i].hs_d);
            #1;
            chk("gnt",      i, 64'(gnt_v), 64'(tbl[i].gnt));
            chk("mem",      i, 64'(mem_v), 64'(tbl[i].mem));
            chk("rvalid",   i, 64'(rv_v), 64'(tbl[i].rv));
            chk("if_rdata", i, 64'(bus.if_rdata), 64'(tbl[i].if_rd));
            chk("dm_rdata", i, 64'(bus.dm_rdata), 64'(tbl[i].dm_rd));
            chk("hs_rdata", i, 64'(bus.hs_rdata), 64'(tbl[i].hs_rd));
            chk("busy",     i, 64'(bus.busy), 64'(tbl[i].busy));
        end

        // write then read of the top word, back to back from DM
        @(negedge clk);
        drive(3'b010, 1'b1, 1'b0, 1'b0, A, 12'hFFF, A, 32'h55, 0);
        #1;
        chk("wr_gnt", 100, 64'(gnt_v), 64'(3'b010));
        @(negedge clk);
        drive(3'b010, 1'b0, 1'b0, 1'b0, A, 12'hFFF, A, 0, 0);
        #1;
        chk("rd_gnt", 101, 64'(gnt_v), 64'(3'b010));
        chk("wr_mem", 101, 64'(mem_v), 64'({2'b11, 12'hFFF}));
        chk("wr_wd",  101, 64'(bus.mem_wdata), 64'(32'h55));
        @(negedge clk);
        drive(3'b000, 1'b0, 1'b0, 1'b0, A, A, A, 0, 0);
        #1;
        chk("rd_mem", 102, 64'(mem_v), 64'({2'b10, 12'hFFF}));
        chk("wr_norv", 102, 64'(rv_v), 64'(3'b000));
        @(negedge clk);
        #1;
        chk("wr_norv", 103, 64'(rv_v), 64'(3'b000));
        @(negedge clk);
        #1;
        chk("rd_rv",   104, 64'(rv_v), 64'(3'b010));
        chk("rd_data", 104, 64'(bus.dm_rdata), 64'(32'h55));

        // host lock keeps DM out until hs_lock drops
        @(negedge clk);
        drive(3'b100, 1'b0, 1'b1, 1'b1, A, A, 12'h100, 0, 32'hA5A50001);
        #1;
        chk("lk_gnt", 200, 64'(gnt_v), 64'(3'b100));
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(3'b110, 1'b0, 1'b1, 1'b1, A, A, 12'h100, 0, 32'hA5A50001);
            #1;
            chk("lk_gnt", 200 + k, 64'(gnt_v), 64'(3'b100));
        end
        @(negedge clk);
        drive(3'b110, 1'b0, 1'b1, 1'b0, A, A, 12'h100, 0, 32'hA5A50001);
        #1;
        chk("unlk_gnt", 204, 64'(gnt_v), 64'(3'b010));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(3'b000, 1'b0, 1'b0, 1'b0, A, A, A, 0, 0);
        end

        // reset while an IF read is in flight
        @(negedge clk);
        drive(3'b001, 1'b0, 1'b0, 1'b0, A, A, A, 0, 0);
        #1;
        chk("mr_gnt", 300, 64'(gnt_v), 64'(3'b001));
        @(negedge clk);
        rst_n = 1'b0;
        drive(3'b111, 1'b0, 1'b0, 1'b0, A, A, A, 0, 0);
        #1;
        chk("mr_rgnt", 301, 64'(gnt_v), 64'(3'b000));
        chk("mr_mem",  301, 64'(mem_v), 64'(14'h0));
        chk("mr_busy", 301, 64'(bus.busy), 64'(1'b0));
        chk("mr_ird",  301, 64'(bus.if_rdata), 64'(32'h0));
        chk("mr_hrd",  301, 64'(bus.hs_rdata), 64'(32'h0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 1'b0, A, A, A, 0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("mr_norv", 302 + k, 64'(rv_v), 64'(3'b000));
        end
        @(negedge clk);
        drive(3'b111, 1'b0, 1'b0, 1'b0, A, B, A, 0, 0);
        #1;
        chk("mr_first", 306, 64'(gnt_v), 64'(3'b001));
        @(negedge clk);
        drive(3'b000, 1'b0, 1'b0, 1'b0, A, A, A, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 4096 x 32-bit data/instruction RAM among three requesters: instruction fetch (IF), data load/store (DM) and a host/boot loader (HS).
- Accepts at most one access per cycle using round-robin priority.
- Drives a registered command stage into the synchronous RAM and routes returned read data back to the requester that issued the read.
- Sits between the fetcher, the execute stage (lw/sw) and the RAM array.

Parameters:
ADDR_W, 12, RAM word-address width (4096 words)
DATA_W, 32, word width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request (valid)
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch request accepted this cycle (ready)
if_rdata  out  DATA_W  fetch read data
if_rvalid  out  1  if_rdata valid, 1-cycle pulse
dm_req  in  1  data request
dm_we  in  1  1=write, 0=read
dm_addr  in  ADDR_W  data word address
dm_wdata  in  DATA_W  data write word
dm_gnt  out  1  data request accepted
dm_rdata  out  DATA_W  data read data
dm_rvalid  out  1  dm_rdata valid pulse
hs_req  in  1  host request
hs_we  in  1  host write enable
hs_addr  in  ADDR_W  host address
hs_wdata  in  DATA_W  host write word
hs_lock  in  1  host requests exclusive back-to-back ownership
hs_gnt  out  1  host request accepted
hs_rdata  out  DATA_W  host read data
hs_rvalid  out  1  hs_rdata valid pulse
mem_en  out  1  RAM access strobe (registered)
mem_we  out  1  RAM write enable (registered)
mem_addr  out  ADDR_W  RAM address (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en&~mem_we
busy  out  1  command or read return in flight

Behaviour:
- Handshake: a transfer occurs on the rising edge where x_req & x_gnt. Requester holds req/we/addr/wdata stable until then. At most one x_gnt high per cycle. x_gnt is combinational from the req inputs and registered arbitration state; it never asserts while x_req=0.
- Arbitration: round-robin over order IF(0), DM(1), HS(2). Search starts at the requester after last_gnt. last_gnt updates on each accept. Reset value last_gnt=HS, so IF has first priority.
- Host lock: if the previous accept was HS with hs_lock=1, and hs_req=1 now, HS wins unconditionally. Lock ends on the first cycle with hs_lock=0 or hs_req=0; round-robin then resumes from HS.
- Command stage: on the accept edge, mem_en<=1 and mem_we/addr/wdata<=the winner's fields (IF always reads). With no accept, mem_en<=0 and the other mem_* hold their value. Full throughput: one accept per cycle, no bubbles.
- Read return:
  - A 2-bit tag of the accepted reader is registered alongside the command.
  - On the edge after mem_en&~mem_we, mem_rdata is registered into the tagged x_rdata and x_rvalid<=1 for exactly one cycle.
  - Read latency is exactly 2 edges from the accept edge to rvalid high.
  - Writes produce no rvalid.
  - x_rdata holds its last value when not valid.
- Ordering: accepts complete in acceptance order. A write accepted at edge k is visible to a read accepted at edge k+1.
- busy = mem_en | any pending read-return tag.
- Reset (asynchronous, any time, including mid-access):
  - All gnt, rvalid and mem_en = 0.
  - mem_we=0, mem_addr=0, mem_wdata=0, all x_rdata=0.
  - last_gnt=HS, lock cleared.
  - In-flight reads are discarded: no rvalid after rst_n rises.
  - First accept is possible on the first edge with rst_n high.
- Simultaneous events: a new accept and a read return for a different requester occur in the same cycle independently.

Test Plan:
- Single read: write RAM[0x010]=0xDEADBEEF, then if_req with if_addr=0x010 -> if_gnt high in the same cycle; mem_en=1 and mem_addr=0x010 next cycle; if_rvalid=1 with if_rdata=0xDEADBEEF 2 edges after accept, for 1 cycle.
- Round-robin: if_req, dm_req and hs_req held high for 6 cycles after reset -> grant sequence IF, DM, HS, IF, DM, HS; mem_en=1 every cycle.
- Host lock: hs_lock=1, hs_req held high for 4 cycles with dm_req high -> four consecutive hs_gnt; dm_gnt appears on the cycle hs_lock drops.
- Write-then-read: dm write 0x00000055 to 0x0FFF accepted at edge k, dm read 0x0FFF accepted at edge k+1 -> dm_rvalid at edge k+3 with dm_rdata=0x00000055; no rvalid for the write.
- Reset mid-read: IF read accepted, rst_n pulled low before the return edge -> if_rvalid never asserts; all outputs 0 immediately; after release, IF wins the first contended cycle.
- Idle: no requests -> all gnt=0, mem_en=0, busy=0; mem_addr holds its previous value.
